// File: rtl/bus8088_pkg.sv
// Shared types for the 8088-style bus initiator: bus phase encoding and latched request.
package bus8088_pkg;

  localparam int unsigned IO_ADDR_W = 16;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } bus_state_t;

  typedef struct packed {
    logic        write;
    logic        iom;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/bus8088_wait_timer.sv
// Consecutive wait-state counter; flags expiry on the last permitted TW cycle.
// Only built with BUS8088_WAIT_TIMEOUT_EN.
`ifdef BUS8088_WAIT_TIMEOUT_EN
module bus8088_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = count_en && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bus8088_initiator.sv
// 8088-style bus initiator: single-beat requests become T1..T4 cycles with READY wait states.
// Optional wait-state timeout abort under BUS8088_WAIT_TIMEOUT_EN.
module bus8088_initiator
  import bus8088_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [19:0] IO_ADDR_MASK   = 20'((1 << IO_ADDR_W) - 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_iom,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        ALE,
  output logic        IOM,
  output logic        rd,
  output logic        wr,
  output logic        den,
  output logic        dt_r,
  input  logic        READY,
  output logic [19:0] addr,
  inout  tri logic [7:0] data
);

  bus_state_t state, state_nxt;
  bus_req_t   req_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       accept;
  logic       timed_out;
  logic       wait_done;
  logic       in_cycle;
  logic       strobe;
  logic       data_phase;

`ifdef BUS8088_WAIT_TIMEOUT_EN
  bus8088_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state == T2),
    .count_en (state == TW),
    .expired  (timed_out)
  );
`else
  // Timeout length is only meaningful with the timer; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timed_out          = 1'b0;
`endif

  assign req_ready = reset_n && ((state == IDLE) || (state == T4));
  assign accept    = req_valid && req_ready;
  assign wait_done = ((state == T3) || (state == TW)) && (READY || timed_out);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, T4: state_nxt = accept ? T1 : IDLE;
      T1:       state_nxt = T2;
      T2:       state_nxt = T3;
      T3, TW:   state_nxt = wait_done ? T4 : TW;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q.write <= req_write;
        req_q.iom   <= req_iom;
        req_q.addr  <= req_iom ? (req_addr & IO_ADDR_MASK) : req_addr;
        req_q.wdata <= req_wdata;
      end
      // READY wins over a simultaneous timeout expiry.
      if (wait_done) begin
        err_q   <= !READY;
        rdata_q <= !READY ? 8'hFF : (req_q.write ? 8'h00 : data);
      end
    end
  end

  assign in_cycle   = (state == T1) || (state == T2) || (state == T3) || (state == TW) || (state == T4);
  assign strobe     = (state == T2) || (state == T3) || (state == TW);
  assign data_phase = strobe || (state == T4);

  assign ALE       = (state == T1);
  assign IOM       = in_cycle && req_q.iom;
  assign dt_r      = in_cycle && req_q.write;
  assign rd        = !(strobe && !req_q.write);
  assign wr        = !(strobe && req_q.write);
  assign den       = !data_phase;
  assign addr      = req_q.addr;
  assign data      = (data_phase && req_q.write) ? req_q.wdata : 8'hzz;
  assign rsp_valid = (state == T4);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_bus8088_initiator.sv
// Self-checking bench for bus8088_initiator: directed table, hand sequences and random traffic
// against a byte-memory responder and an address-keyed reference model.
module tb_bus8088_initiator;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_iom = 1'b0;
  logic        req_ready;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        ALE, IOM, rd, wr, den, dt_r;
  logic        READY = 1'b0;
  logic [19:0] addr;
  tri   [7:0]  data;

  logic        tb_drive = 1'b0, tb_force = 1'b0;
  logic [7:0]  tb_data = '0;
  assign data = (tb_drive || tb_force) ? (tb_force ? 8'h5A : tb_data) : 8'hzz;

  bus8088_initiator #(
    .TIMEOUT_CYCLES(TMO),
    .IO_ADDR_MASK  (20'h0FFFF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_iom(req_iom),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .IOM(IOM), .rd(rd), .wr(wr), .den(den), .dt_r(dt_r),
    .READY(READY), .addr(addr), .data(data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] dflt(bit [20:0] k);
    int v;
    v = int'(k[7:0]) * 3 + int'(k[15:8]) + int'(k[19:16]) * 17 + int'(k[20]) * 5;
    return v[7:0];
  endfunction

  // ---------------- responder: byte memory keyed by {IOM, addr} ----------------
  logic [7:0]  resp_mem [bit [20:0]];
  int unsigned ready_q[$];
  int unsigned cur_wait = 0;
  int unsigned sc = 0;

  always @(negedge clk) begin
    bit [20:0] key;
    key = {IOM, addr};
    if (!rd || !wr) begin
      if (sc == 0) cur_wait = (ready_q.size() > 0) ? ready_q.pop_front() : 0;
      sc++;
      if (sc < 2) READY = 1'($urandom);
      else        READY = (sc >= 2 + cur_wait);
      if (!rd) begin
        tb_data  = resp_mem.exists(key) ? resp_mem[key] : dflt(key);
        tb_drive = 1'b1;
      end
      if (!wr) resp_mem[key] = data;
    end else begin
      sc       = 0;
      tb_drive = 1'b0;
      READY    = 1'($urandom);
    end
  end

  // ---------------- monitor: one record per completed bus cycle ----------------
  typedef struct {
    int unsigned ale_cyc, rsp_cyc, ale_n, strb_n, den_n;
    logic [19:0] a;
    logic        iom, dtr;
    logic [7:0]  wd, rdata;
    logic        err;
    bit          seen_wd, wd_ok, both_low, stable;
  } obs_t;

  obs_t cur, prev_o, last_o;
  obs_t obs_q[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      cur = '{default: 0};
    end else begin
      if (ALE) begin
        cur        = '{default: 0};
        cur.ale_cyc = cyc;
        cur.a      = addr;
        cur.iom    = IOM;
        cur.dtr    = dt_r;
        cur.wd_ok  = 1;
        cur.stable = 1;
      end
      cur.ale_n += 32'(ALE);
      if (ALE || !den) begin
        if (addr !== cur.a || IOM !== cur.iom || dt_r !== cur.dtr) cur.stable = 0;
      end
      if (!rd || !wr) cur.strb_n++;
      if (!rd && !wr) cur.both_low = 1;
      if (!den) begin
        cur.den_n++;
        if (dt_r) begin
          if (!cur.seen_wd) begin cur.wd = data; cur.seen_wd = 1; end
          else if (data !== cur.wd) cur.wd_ok = 0;
        end
      end
      if (rsp_valid) begin
        cur.rsp_cyc = cyc;
        cur.rdata   = rsp_rdata;
        cur.err     = rsp_err;
        obs_q.push_back(cur);
      end
    end
  end

  // ---------------- reference model and expectations ----------------
  typedef struct {
    int unsigned acc_cyc, tw;
    logic        w, iom;
    logic [19:0] a;
    logic [7:0]  wd, rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] model_mem [bit [20:0]];

  function automatic bit [20:0] mkey(logic iom, logic [19:0] a);
    return iom ? {1'b1, 20'(a % 20'h10000)} : {1'b0, a};
  endfunction

  function automatic logic [7:0] model_read(bit [20:0] k);
    return model_mem.exists(k) ? model_mem[k] : dflt(k);
  endfunction

  task automatic issue(input logic w, input logic iom, input logic [19:0] a, input logic [7:0] wd,
                       input int unsigned waits, input logic [7:0] exp_rd, input logic [19:0] exp_a,
                       input logic exp_err);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_iom = iom; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc; e.tw = exp_err ? TMO : waits; e.w = w; e.iom = iom;
    e.a = exp_a; e.wd = wd; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    ready_q.push_back(waits);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_iom = 1'($urandom);
    req_addr = 20'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic drain();
    int unsigned n = 0;
    exp_t e;
    obs_t o;
    while (obs_q.size() < exp_q.size() && n < 400) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk("missing_rsp", 0, 1);
        continue;
      end
      o = obs_q.pop_front();
      prev_o = last_o;
      last_o = o;
      chk("ale_delay", o.ale_cyc - e.acc_cyc, 1);
      chk("latency", o.rsp_cyc - e.acc_cyc, 4 + e.tw);
      chk("ale_count", o.ale_n, 1);
      chk("strobe_cycles", o.strb_n, 2 + e.tw);
      chk("den_cycles", o.den_n, 3 + e.tw);
      chk("addr", o.a, e.a);
      chk("iom", o.iom, e.iom);
      chk("dt_r", o.dtr, e.w);
      chk("ctrl_stable", o.stable, 1);
      chk("rd_wr_overlap", o.both_low, 0);
      chk("rsp_rdata", o.rdata, e.rdata);
      chk("rsp_err", o.err, e.err);
      if (e.w) begin
        chk("wdata", o.wd, e.wd);
        chk("wdata_stable", o.wd_ok, 1);
      end
    end
  endtask

  typedef struct {
    logic        w, iom;
    logic [19:0] a;
    logic [7:0]  wd;
    int unsigned waits;
    logic [7:0]  exp_rd;
    logic [19:0] exp_a;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{w: 0, iom: 0, a: 20'h00010, wd: 8'h00, waits: 0, exp_rd: 8'hA5, exp_a: 20'h00010};
    vecs[1] = '{w: 1, iom: 0, a: 20'h80004, wd: 8'h3C, waits: 0, exp_rd: 8'h00, exp_a: 20'h80004};
    vecs[2] = '{w: 0, iom: 0, a: 20'h80004, wd: 8'h00, waits: 0, exp_rd: 8'h3C, exp_a: 20'h80004};
    vecs[3] = '{w: 0, iom: 1, a: 20'h3FF05, wd: 8'h00, waits: 3, exp_rd: 8'h5E, exp_a: 20'h0FF05};
    vecs[4] = '{w: 1, iom: 1, a: 20'h12345, wd: 8'h9B, waits: 1, exp_rd: 8'h00, exp_a: 20'h02345};
    vecs[5] = '{w: 0, iom: 1, a: 20'h02345, wd: 8'h00, waits: 2, exp_rd: 8'h9B, exp_a: 20'h02345};

    resp_mem[{1'b0, 20'h00010}]  = 8'hA5;
    model_mem[{1'b0, 20'h00010}] = 8'hA5;
    resp_mem[{1'b1, 20'h0FF05}]  = 8'h5E;
    model_mem[{1'b1, 20'h0FF05}] = 8'h5E;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ALE", ALE, 0);
    chk("rst_IOM", IOM, 0);
    chk("rst_rd", rd, 1);
    chk("rst_wr", wr, 1);
    chk("rst_den", den, 1);
    chk("rst_dt_r", dt_r, 0);
    chk("rst_addr", addr, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    tb_force = 1'b1;
    #1 chk("rst_data_released", data, 8'h5A);
    tb_force = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].w, vecs[i].iom, vecs[i].a, vecs[i].wd, vecs[i].waits,
            vecs[i].exp_rd, vecs[i].exp_a, 1'b0);
      if (vecs[i].w) model_mem[mkey(vecs[i].iom, vecs[i].a)] = vecs[i].wd;
      drain();
    end

    // back-to-back: second ALE directly follows first T4
    issue(1'b1, 1'b0, 20'h00200, 8'h61, 0, 8'h00, 20'h00200, 1'b0);
    model_mem[mkey(1'b0, 20'h00200)] = 8'h61;
    issue(1'b0, 1'b0, 20'h00200, 8'h00, 0, 8'h61, 20'h00200, 1'b0);
    drain();
    chk("b2b_gap", last_o.ale_cyc - prev_o.rsp_cyc, 1);

    // reset during a wait state of a write
    issue(1'b1, 1'b0, 20'h00123, 8'hE7, 6, 8'h00, 20'h00123, 1'b0);
    repeat (4) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_rd", rd, 1);
    chk("midrst_wr", wr, 1);
    chk("midrst_den", den, 1);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    tb_force = 1'b1;
    #1 chk("midrst_data_released", data, 8'h5A);
    tb_force = 1'b0;
    void'(exp_q.pop_back());
    resp_mem.delete({1'b0, 20'h00123});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_rsp", obs_q.size(), 0);
    chk("midrst_idle_ready", req_ready, 1);
    chk("midrst_idle_ALE", ALE, 0);
    @(posedge clk);
    #1;

`ifdef BUS8088_WAIT_TIMEOUT_EN
    issue(1'b0, 1'b0, 20'h00040, 8'h00, 1000, 8'hFF, 20'h00040, 1'b1);
    drain();
`endif

    // random traffic
    for (int i = 0; i < 60; i++) begin
      logic        w, iom;
      logic [19:0] a;
      logic [7:0]  wd, er;
      int unsigned waits;
      bit [20:0]   k;
      w     = 1'($urandom);
      iom   = 1'($urandom);
      a     = {4'($urandom), 12'h000, 4'($urandom)};
      wd    = 8'($urandom);
      waits = $urandom_range(0, 4);
      k     = mkey(iom, a);
      er    = w ? 8'h00 : model_read(k);
      if (w) model_mem[k] = wd;
      issue(w, iom, a, wd, waits, er, k[19:0], 1'b0);
      if (($urandom % 3) == 0 || exp_q.size() >= 3) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
